// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_e;

    // Bit-counter width; a 2-bit word still needs one counter bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Even parity bit: makes the total number of ones (data + parity) even.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Counts serial bit times within a word and flags the last data bit.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic last
);

    localparam int CNT_W = cnt_width(WIDTH);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == CNT_W'(WIDTH - 1));

    // Saturates at WIDTH-1: the FSM leaves SHIFT on that increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !last) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready word input and clken-paced bit times.
// Optional trailing even-parity bit enabled by defining PISO_SERIALIZER_PARITY_EN.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clken,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             SO,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             done_q, done_d;
    logic             take;
    logic             cnt_inc;
    logic             cnt_last;
    logic             out_bit;

    assign take    = (state_q == S_IDLE) && din_valid;
    assign cnt_inc = (state_q == S_SHIFT) && clken;
    assign out_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (take),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

`ifdef PISO_SERIALIZER_PARITY_EN
    logic parity_q, parity_d;

    // Parity is captured from din at transfer, not recomputed from the shifting register.
    always_comb begin
        parity_d = parity_q;
        if (take) begin
            parity_d = even_parity(64'(din));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    shreg_d = din;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (clken) begin
                    shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                    if (cnt_last) begin
`ifdef PISO_SERIALIZER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef PISO_SERIALIZER_PARITY_EN
            S_PARITY: begin
                if (clken) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode only registered state, so an async reset clears them at once.
    always_comb begin
        SO = 1'b0;
        case (state_q)
            S_SHIFT:  SO = out_bit;
`ifdef PISO_SERIALIZER_PARITY_EN
            S_PARITY: SO = parity_q;
`endif
            default:  SO = 1'b0;
        endcase
    end

    assign so_valid  = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign din_ready = (state_q == S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (LSB-first and MSB-first instances).
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clken;
    logic       din_valid;
    logic [7:0] din;
    logic       din_ready, so, so_valid, busy, done;

    logic       clken_m;
    logic       din_valid_m;
    logic [7:0] din_m;
    logic       din_ready_m, so_m, so_valid_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clken(clken), .din_valid(din_valid), .din(din),
        .din_ready(din_ready), .SO(so), .so_valid(so_valid), .busy(busy), .done(done)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .clken(clken_m), .din_valid(din_valid_m), .din(din_m),
        .din_ready(din_ready_m), .SO(so_m), .so_valid(so_valid_m), .busy(busy_m), .done(done_m)
    );

    task automatic test_reset();
        rst_n = 1'b0; clken = 1'b1; din_valid = 1'b0; din = 8'h00;
        clken_m = 1'b1; din_valid_m = 1'b0; din_m = 8'h00;
        #12;
        checks++;
        if ({so, so_valid, busy, done, din_ready} !== 5'b00001) begin
            errors++; $display("FAIL reset_outputs got %b want 00001", {so, so_valid, busy, done, din_ready});
        end
        checks++;
        if ({so_m, so_valid_m, busy_m, done_m, din_ready_m} !== 5'b00001) begin
            errors++; $display("FAIL reset_outputs_msb got %b want 00001", {so_m, so_valid_m, busy_m, done_m, din_ready_m});
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Sends one word with clken=1 and checks each bit plus the done cycle.
    task automatic test_basic(input logic [7:0] w, input logic par);
        @(negedge clk); din = w; din_valid = 1'b1; clken = 1'b1;
        @(negedge clk); din_valid = 1'b0; din = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (so !== w[i] || so_valid !== 1'b1) begin
                errors++; $display("FAIL basic_%h_bit%0d got so=%b vld=%b want so=%b vld=1", w, i, so, so_valid, w[i]);
            end
            checks++;
            if ({din_ready, busy, done} !== 3'b010) begin
                errors++; $display("FAIL basic_%h_ctl%0d got rdy/busy/done=%b want 010", w, i, {din_ready, busy, done});
            end
            @(negedge clk);
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        checks++;
        if (so !== par || so_valid !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL parity_%h got so=%b vld=%b done=%b want so=%b vld=1 done=0", w, so, so_valid, done, par);
        end
        @(negedge clk);
`else
        checks++;
        if (par !== 1'b0 && par !== 1'b1) begin
            errors++; $display("FAIL parity_arg_%h got %b want 0/1", w, par);
        end
`endif
        checks++;
        if ({done, din_ready, so_valid, so, busy} !== 5'b11000) begin
            errors++; $display("FAIL basic_%h_done got done/rdy/vld/so/busy=%b want 11000", w, {done, din_ready, so_valid, so, busy});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL basic_%h_done_pulse got %b want 0", w, done);
        end
    endtask

    task automatic test_clken_half();
        logic [7:0] w;
        int nbits;
        w = 8'hA5;
        nbits = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
        nbits = 9;
`endif
        @(negedge clk); din = w; din_valid = 1'b1; clken = 1'b0;
        @(negedge clk); din_valid = 1'b0;
        for (int k = 0; k < 2 * nbits; k++) begin
            logic expb;
            expb = (k / 2 < 8) ? w[k/2] : 1'b0;
            checks++;
            if (so !== expb || so_valid !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL clken_k%0d got so=%b vld=%b done=%b want so=%b vld=1 done=0", k, so, so_valid, done, expb);
            end
            clken = k[0];
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || din_ready !== 1'b1 || so_valid !== 1'b0) begin
            errors++; $display("FAIL clken_done got done=%b rdy=%b vld=%b want 1 1 0", done, din_ready, so_valid);
        end
        clken = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        logic [7:0] w;
        w = 8'h80;
        @(negedge clk); din_m = w; din_valid_m = 1'b1; clken_m = 1'b1;
        @(negedge clk); din_valid_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (so_m !== w[7-i] || so_valid_m !== 1'b1) begin
                errors++; $display("FAIL msb_bit%0d got so=%b vld=%b want so=%b vld=1", i, so_m, so_valid_m, w[7-i]);
            end
            @(negedge clk);
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        checks++;
        if (so_m !== 1'b1) begin
            errors++; $display("FAIL msb_parity got %b want 1", so_m);
        end
        @(negedge clk);
`endif
        checks++;
        if (done_m !== 1'b1 || so_valid_m !== 1'b0) begin
            errors++; $display("FAIL msb_done got done=%b vld=%b want 1 0", done_m, so_valid_m);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] both;
        logic [1:0]  pars;
        int nbits;
        both  = 16'hF00F;
        pars  = 2'b00;
        nbits = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
        nbits = 9;
`endif
        @(negedge clk); din = 8'h0F; din_valid = 1'b1; clken = 1'b1;
        @(negedge clk); din = 8'hF0;
        for (int wd = 0; wd < 2; wd++) begin
            for (int i = 0; i < nbits; i++) begin
                logic expb;
                expb = (i < 8) ? both[wd*8 + i] : pars[wd];
                checks++;
                if (so !== expb || so_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_w%0d_bit%0d got so=%b vld=%b want so=%b vld=1", wd, i, so, so_valid, expb);
                end
                @(negedge clk);
            end
            checks++;
            if (done !== 1'b1 || din_ready !== 1'b1 || so_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_gap%0d got done=%b rdy=%b vld=%b want 1 1 0", wd, done, din_ready, so_valid);
            end
            @(negedge clk);
            din_valid = 1'b0;
        end
        checks++;
        if (so_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_after got vld=%b busy=%b want 0 0", so_valid, busy);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); din = 8'hFF; din_valid = 1'b1; clken = 1'b1;
        @(negedge clk); din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (so !== 1'b1 || so_valid !== 1'b1) begin
                errors++; $display("FAIL areset_pre_bit%0d got so=%b vld=%b want 1 1", i, so, so_valid);
            end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({so, so_valid, busy, done, din_ready} !== 5'b00001) begin
            errors++; $display("FAIL areset_immediate got %b want 00001", {so, so_valid, busy, done, din_ready});
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || so_valid !== 1'b0) begin
                errors++; $display("FAIL areset_quiet%0d got done=%b vld=%b want 0 0", i, done, so_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(8'hA5, 1'b0);
        test_clken_half();
        test_msb_first();
        test_back_to_back();
        test_async_reset();
        test_basic(8'h3C, 1'b0);
`ifdef PISO_SERIALIZER_PARITY_EN
        test_basic(8'h07, 1'b1);
        test_basic(8'h03, 1'b0);
`else
        test_basic(8'h07, 1'b1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
